// File: rtl/rv32_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM and feeds decode through a
// 2-entry {instr, pc} FIFO. Fetch stops after an ECALL is enqueued until the next redirect.
module rv32_fetch_unit #(
  parameter int unsigned        ADDRLEN  = 10,
  parameter int unsigned        XLEN     = 32,
  parameter logic [ADDRLEN-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDRLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0]    i_imem_data,
  input  logic               i_redirect_valid,
  input  logic [ADDRLEN-1:0] i_redirect_pc,
  output logic               o_if_valid,
  input  logic               i_if_ready,
  output logic [XLEN-1:0]    o_if_instr,
  output logic [ADDRLEN-1:0] o_if_pc,
  output logic               o_halted
);

  localparam logic [XLEN-1:0] Ecall = XLEN'(32'h0000_0073);

  typedef enum logic {StRun, StHalt} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [ADDRLEN-1:0] r_pc;
  logic [1:0]         r_count;
  logic [XLEN-1:0]    r_head_instr;
  logic [ADDRLEN-1:0] r_head_pc;
  logic [XLEN-1:0]    r_tail_instr;
  logic [ADDRLEN-1:0] r_tail_pc;

  logic               w_pop;
  logic               w_push;
  logic [ADDRLEN-1:0] w_redirect_target;

  assign w_pop             = (r_count != 2'd0) & i_if_ready;
  assign w_push            = (r_state == StRun) & ~i_redirect_valid &
                             ((r_count != 2'd2) | w_pop);
  assign w_redirect_target = i_redirect_pc & ~ADDRLEN'(3);

  always_comb begin
    w_state_d = r_state;
    if (i_redirect_valid) begin
      w_state_d = StRun;
    end else if (w_push && (i_imem_data == Ecall)) begin
      w_state_d = StHalt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Head is a register so that it keeps its last value once the FIFO drains.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc         <= RESET_PC;
      r_count      <= 2'd0;
      r_head_instr <= '0;
      r_head_pc    <= '0;
      r_tail_instr <= '0;
      r_tail_pc    <= '0;
    end else if (i_redirect_valid) begin
      r_pc    <= w_redirect_target;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc <= r_pc + ADDRLEN'(4);
      end
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_instr <= i_imem_data;
            r_head_pc    <= r_pc;
          end else begin
            r_tail_instr <= i_imem_data;
            r_tail_pc    <= r_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_instr <= i_imem_data;
            r_head_pc    <= r_pc;
          end else begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_tail_instr <= i_imem_data;
            r_tail_pc    <= r_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_imem_addr = r_pc;
  assign o_if_valid  = (r_count != 2'd0);
  assign o_if_instr  = r_head_instr;
  assign o_if_pc     = r_head_pc;
  assign o_halted    = (r_state == StHalt);

endmodule
